// File: rtl/stopwatch_bcd_core_pkg.sv
// stopwatch_pkg: shared types, digit limits and the MAX_MIN split helper
// for the MM:SS stopwatch core.
//   state_t     - controller states
//   bcd_t       - one BCD digit
//   step_t      - result of a single-digit step (digit + carry/borrow out)
//   bcd_pair_t  - a two-digit decimal value split into tens/units
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX   = 4'd9;
    localparam bcd_t SEC_TEN_MAX = 4'd5;

    typedef struct packed {
        logic carry;
        bcd_t digit;
    } step_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd_pair_t;

    // Only meaningful for 0..99; used to turn MAX_MIN into digit limits.
    function automatic bcd_pair_t split_bcd(input int value);
        bcd_pair_t r;
        r.tens  = bcd_t'(value / 10);
        r.units = bcd_t'(value % 10);
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_core_if.sv
// stopwatch_bcd_core_if: control pulses/levels from the button logic and
// the BCD time/status outputs towards the display multiplexer.
//   master: drives start_stop, clear, adj_en, adj_sel, dir; reads digits
//   slave : the stopwatch core
interface stopwatch_bcd_core_if;
    import stopwatch_pkg::*;

    logic start_stop;
    logic clear;
    logic adj_en;
    logic adj_sel;
    logic dir;
    bcd_t sec_one;
    bcd_t sec_ten;
    bcd_t min_one;
    bcd_t min_ten;
    logic running;
    logic rollover;

    modport master (
        output start_stop, clear, adj_en, adj_sel, dir,
        input  sec_one, sec_ten, min_one, min_ten, running, rollover
    );

    modport slave (
        input  start_stop, clear, adj_en, adj_sel, dir,
        output sec_one, sec_ten, min_one, min_ten, running, rollover
    );

endinterface

// File: rtl/stopwatch_bcd_core_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle enable every DIV
// clocks.
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   clr  - synchronous restart of the count from zero
//   tick - high for the single cycle where the count equals DIV-1
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core: MM:SS stopwatch/timer with BCD outputs.
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - slave side of stopwatch_bcd_core_if (controls in, digits,
//              running and rollover out)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   STOPPED | digits hold
//   RUNNING | digits step once per count tick, up (dir=0) or down (dir=1)
//   ADJUST  | selected field (adj_sel) increments once per adjust tick
module stopwatch_bcd_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int ADJ_HZ  = 2,
    parameter int MAX_MIN = 59
) (
    input logic clk,
    input logic rst,
    stopwatch_bcd_core_if.slave bus
);

    localparam int        TICK_DIV    = CLK_HZ / TICK_HZ;
    localparam int        ADJ_DIV     = CLK_HZ / ADJ_HZ;
    localparam bcd_pair_t MAX_MIN_BCD = split_bcd(MAX_MIN);

    typedef struct packed {
        logic wrap;
        bcd_t ten;
        bcd_t one;
    } min_step_t;

    function automatic step_t step_digit(input bcd_t d, input logic down,
                                         input bcd_t lim);
        step_t r;
        if (!down) begin
            r.carry = (d >= lim);
            r.digit = (d >= lim) ? 4'd0 : d + 4'd1;
        end else begin
            r.carry = (d == 4'd0);
            r.digit = (d == 4'd0) ? lim : d - 4'd1;
        end
        return r;
    endfunction

    // Minutes wrap on the full two-digit value, so the tens digit never
    // needs its own limit: below MAX_MIN a units carry can always go up.
    function automatic min_step_t step_minutes(input bcd_t ten, input bcd_t one,
                                               input logic down);
        min_step_t r;
        step_t     u;
        r.wrap = 1'b0;
        r.ten  = ten;
        r.one  = one;
        if (!down) begin
            if (ten == MAX_MIN_BCD.tens && one == MAX_MIN_BCD.units) begin
                r.ten  = 4'd0;
                r.one  = 4'd0;
                r.wrap = 1'b1;
            end else begin
                u     = step_digit(one, 1'b0, DIGIT_MAX);
                r.one = u.digit;
                if (u.carry) r.ten = ten + 4'd1;
            end
        end else begin
            if (ten == 4'd0 && one == 4'd0) begin
                r.ten  = MAX_MIN_BCD.tens;
                r.one  = MAX_MIN_BCD.units;
                r.wrap = 1'b1;
            end else begin
                u     = step_digit(one, 1'b1, DIGIT_MAX);
                r.one = u.digit;
                if (u.carry) r.ten = ten - 4'd1;
            end
        end
        return r;
    endfunction

    state_t    state, state_n;
    bcd_t      sec_one, sec_ten, min_one, min_ten;
    bcd_t      sec_one_n, sec_ten_n, min_one_n, min_ten_n;
    logic      rollover, rollover_n;
    logic      tick, adj_tick;
    logic      tick_clr, adj_clr;
    step_t     s1, s2;
    min_step_t ms;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    tick_gen #(.DIV(ADJ_DIV)) u_adj_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (adj_clr),
        .tick (adj_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STOPPED;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.clear) begin
            state_n = STOPPED;
        end else if (bus.adj_en) begin
            state_n = ADJUST;
        end else if (state == ADJUST) begin
            state_n = STOPPED;
        end else if (bus.start_stop) begin
            state_n = (state == RUNNING) ? STOPPED : RUNNING;
        end
    end

    // Restarting the prescaler on entry makes the first step land exactly
    // one full period after the start pulse.
    assign tick_clr = bus.clear || (state_n == RUNNING && state != RUNNING);
    assign adj_clr  = (state_n == ADJUST && state != ADJUST);

    always_comb begin
        sec_one_n  = sec_one;
        sec_ten_n  = sec_ten;
        min_one_n  = min_one;
        min_ten_n  = min_ten;
        rollover_n = 1'b0;
        s1         = '0;
        s2         = '0;
        ms         = '0;
        if (bus.clear) begin
            sec_one_n = 4'd0;
            sec_ten_n = 4'd0;
            min_one_n = 4'd0;
            min_ten_n = 4'd0;
        end else if (state == RUNNING && tick) begin
            s1        = step_digit(sec_one, bus.dir, DIGIT_MAX);
            sec_one_n = s1.digit;
            if (s1.carry) begin
                s2        = step_digit(sec_ten, bus.dir, SEC_TEN_MAX);
                sec_ten_n = s2.digit;
                if (s2.carry) begin
                    ms         = step_minutes(min_ten, min_one, bus.dir);
                    min_ten_n  = ms.ten;
                    min_one_n  = ms.one;
                    rollover_n = ms.wrap;
                end
            end
        end else if (state == ADJUST && adj_tick) begin
            if (bus.adj_sel) begin
                ms        = step_minutes(min_ten, min_one, 1'b0);
                min_ten_n = ms.ten;
                min_one_n = ms.one;
            end else begin
                // Seconds wrap on their own; no carry into minutes here.
                s1        = step_digit(sec_one, 1'b0, DIGIT_MAX);
                sec_one_n = s1.digit;
                if (s1.carry) begin
                    s2        = step_digit(sec_ten, 1'b0, SEC_TEN_MAX);
                    sec_ten_n = s2.digit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_one  <= 4'd0;
            sec_ten  <= 4'd0;
            min_one  <= 4'd0;
            min_ten  <= 4'd0;
            rollover <= 1'b0;
        end else begin
            sec_one  <= sec_one_n;
            sec_ten  <= sec_ten_n;
            min_one  <= min_one_n;
            min_ten  <= min_ten_n;
            rollover <= rollover_n;
        end
    end

    assign bus.sec_one  = sec_one;
    assign bus.sec_ten  = sec_ten;
    assign bus.min_one  = min_one;
    assign bus.min_ten  = min_ten;
    assign bus.running  = (state == RUNNING);
    assign bus.rollover = rollover;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// tb_stopwatch_bcd_core: directed checks of the stopwatch core with
// CLK_HZ=20, TICK_HZ=2 (10 clocks/tick), ADJ_HZ=4 (5 clocks/step), MAX_MIN=59.
module tb_stopwatch_bcd_core;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   roll_cnt;

    stopwatch_bcd_core_if bus ();

    stopwatch_bcd_core #(
        .CLK_HZ  (20),
        .TICK_HZ (2),
        .ADJ_HZ  (4),
        .MAX_MIN (59)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rollover === 1'b1) roll_cnt++;
    end

    function automatic logic [15:0] mmss();
        return {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start_stop = 1'b1;
        cyc(1);
        bus.start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        roll_cnt = 0;
        rst = 1'b1;
        bus.start_stop = 1'b0;
        bus.clear = 1'b0;
        bus.adj_en = 1'b0;
        bus.adj_sel = 1'b0;
        bus.dir = 1'b0;

        cyc(3);
        chk("reset_digits", mmss(), 16'h0000);
        chk("reset_running", {15'd0, bus.running}, 16'd0);
        chk("reset_rollover", {15'd0, bus.rollover}, 16'd0);
        rst = 1'b0;
        cyc(2);

        // Count up from zero: first step 10 clocks after the start pulse.
        pulse_start();
        cyc(9);
        chk("first_tick_early", mmss(), 16'h0000);
        chk("running_up", {15'd0, bus.running}, 16'd1);
        cyc(1);
        chk("first_tick", mmss(), 16'h0001);
        cyc(590);
        chk("sixty_ticks", mmss(), 16'h0100);
        pulse_start();
        chk("stop_running", {15'd0, bus.running}, 16'd0);
        chk("stop_hold", mmss(), 16'h0100);

        // Adjust to 59:59: 58 minute steps, then 59 second steps.
        bus.adj_en = 1'b1;
        bus.adj_sel = 1'b1;
        cyc(1 + 5 * 58);
        chk("adj_min_59", mmss(), 16'h5900);
        bus.adj_sel = 1'b0;
        cyc(5 * 59);
        chk("adj_sec_59", mmss(), 16'h5959);
        bus.adj_en = 1'b0;
        cyc(1);
        chk("adj_exit_stopped", {15'd0, bus.running}, 16'd0);
        chk("adj_no_rollover", roll_cnt[15:0], 16'd0);

        // Up wrap from 59:59.
        pulse_start();
        cyc(9);
        chk("wrap_up_before", mmss(), 16'h5959);
        cyc(1);
        chk("wrap_up_digits", mmss(), 16'h0000);
        chk("wrap_up_roll_hi", {15'd0, bus.rollover}, 16'd1);
        cyc(1);
        chk("wrap_up_roll_lo", {15'd0, bus.rollover}, 16'd0);
        chk("wrap_up_count", roll_cnt[15:0], 16'd1);
        pulse_start();

        // Down wrap from 00:00.
        bus.dir = 1'b1;
        pulse_start();
        cyc(9);
        chk("wrap_dn_before", mmss(), 16'h0000);
        cyc(1);
        chk("wrap_dn_digits", mmss(), 16'h5959);
        chk("wrap_dn_roll_hi", {15'd0, bus.rollover}, 16'd1);
        cyc(10);
        chk("down_5958", mmss(), 16'h5958);
        chk("wrap_dn_count", roll_cnt[15:0], 16'd2);

        // Clear while running, then adjust seconds across 59 -> 00.
        pulse_clear();
        chk("clear_digits", mmss(), 16'h0000);
        chk("clear_stopped", {15'd0, bus.running}, 16'd0);
        bus.dir = 1'b0;
        bus.adj_en = 1'b1;
        bus.adj_sel = 1'b0;
        cyc(1 + 5 * 58);
        chk("adj_sec_58", mmss(), 16'h0058);
        cyc(5);
        chk("adj_sec_59b", mmss(), 16'h0059);
        cyc(5);
        chk("adj_sec_wrap", mmss(), 16'h0000);
        bus.adj_sel = 1'b1;
        cyc(5 * 59);
        chk("adj_min_59b", mmss(), 16'h5900);
        cyc(5);
        chk("adj_min_wrap", mmss(), 16'h0000);
        chk("adj_wrap_no_roll", roll_cnt[15:0], 16'd2);
        pulse_start();
        chk("adj_ignores_start", {15'd0, bus.running}, 16'd0);
        bus.adj_en = 1'b0;
        cyc(1);

        // Preload 12:34, run, then clear and start_stop together.
        bus.adj_en = 1'b1;
        bus.adj_sel = 1'b1;
        cyc(1 + 5 * 12);
        bus.adj_sel = 1'b0;
        cyc(5 * 34);
        chk("adj_1234", mmss(), 16'h1234);
        bus.adj_en = 1'b0;
        cyc(1);
        pulse_start();
        cyc(3);
        chk("run_1234", {15'd0, bus.running}, 16'd1);
        bus.clear = 1'b1;
        bus.start_stop = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        bus.start_stop = 1'b0;
        chk("clr_start_digits", mmss(), 16'h0000);
        chk("clr_start_running", {15'd0, bus.running}, 16'd0);
        cyc(10);
        chk("clr_start_hold", mmss(), 16'h0000);

        // Asynchronous reset in the middle of a prescale period.
        pulse_start();
        cyc(15);
        chk("pre_reset_count", mmss(), 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_digits", mmss(), 16'h0000);
        chk("async_rst_running", {15'd0, bus.running}, 16'd0);
        cyc(2);
        rst = 1'b0;
        cyc(12);
        chk("post_rst_hold", mmss(), 16'h0000);
        chk("post_rst_stopped", {15'd0, bus.running}, 16'd0);
        pulse_start();
        cyc(10);
        chk("post_rst_first_tick", mmss(), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
